// File: rtl/vc_buffer_pkg.sv
// Shared flit-type encodings, lock states and default sizing for the VC input buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package vc_buffer_pkg;

  localparam int DEF_FLIT_W = 34;
  localparam int DEF_NUM_VC = 4;
  localparam int DEF_DEPTH  = 4;

  // Flit type lives in the two MSBs of every flit
  localparam logic [1:0] HEAD     = 2'b00;
  localparam logic [1:0] BODY     = 2'b01;
  localparam logic [1:0] HEADTAIL = 2'b10;
  localparam logic [1:0] TAIL     = 2'b11;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  // HEAD and HEADTAIL both start a packet and must not interleave with an open one
  function automatic logic opens_packet(input logic [1:0] ftype);
    return (ftype == HEAD) || (ftype == HEADTAIL);
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// Single-VC flit FIFO with wrap-bit pointers, full/empty flags and occupancy.
// Latency: a write is visible on rd_dat/empty the cycle after the edge that stores it.
// Backpressure: writes while full and reads while empty are ignored; the caller gates on full/empty.
module vc_fifo
  import vc_buffer_pkg::*;
#(
  parameter int FLIT_W = DEF_FLIT_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   wr_en,
  input  logic [FLIT_W-1:0]      wr_dat,
  input  logic                   rd_en,
  output logic [FLIT_W-1:0]      rd_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] ocup
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_wr;
  logic              do_rd;

  // Same low bits: wrap bit tells empty (equal) from full (different)
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                  (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  assign ocup   = wr_ptr - rd_ptr;
  assign do_wr  = wr_en && !full;
  assign do_rd  = rd_en && !empty;
  assign rd_dat = mem[rd_ptr[ADDR_W-1:0]];

  // Storage array carries no reset; stale entries are never exposed because empty masks them
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr[ADDR_W-1:0]] <= wr_dat;
    end
  end

  // Pointer advance; natural overflow of the wrap bit makes DEPTH-1 -> 0 seamless
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/vc_input_buffer.sv
// Router input port buffer: per-VC FIFOs with packet lock tracking and protocol-error flagging.
// Latency: one cycle from an accepted write to valid_o/fdata_o; error_o one cycle after the violation.
// Backpressure: ready_o drops when the target VC is full or a new packet would interleave an open one.
module vc_input_buffer
  import vc_buffer_pkg::*;
#(
  parameter int FLIT_W = DEF_FLIT_W,
  parameter int NUM_VC = DEF_NUM_VC,   // power of two, >= 2
  parameter int DEPTH  = DEF_DEPTH,    // power of two, >= 2
  localparam int VC_W  = $clog2(NUM_VC),
  localparam int OCC_W = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic [VC_W-1:0]         vc_id_i,
  input  logic [FLIT_W-1:0]       fdata_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [VC_W-1:0]         rd_vc_i,
  input  logic                    ready_i,
  output logic [FLIT_W-1:0]       fdata_o,
  output logic [NUM_VC-1:0]       valid_o,
  output logic [NUM_VC*OCC_W-1:0] ocup_o,
  output logic [NUM_VC-1:0]       locked_o,
  output logic                    error_o
);

  logic [1:0]        in_type;
  logic              opens;
  logic              tgt_locked;
  logic              wr_acc;
  logic              orphan;
  logic              store;
  logic              rd_ok;
  logic              rd_err;
  logic              wr_err;
  logic              err_q;
  logic [NUM_VC-1:0] full_v;
  logic [NUM_VC-1:0] empty_v;
  logic [FLIT_W-1:0] rd_dat_a [NUM_VC];
  logic [OCC_W-1:0]  ocup_a   [NUM_VC];
  lock_state_t       lock_q   [NUM_VC];
  lock_state_t       lock_d   [NUM_VC];

  assign in_type    = fdata_i[FLIT_W-1 -: 2];
  assign opens      = opens_packet(in_type);
  assign tgt_locked = (lock_q[vc_id_i] == LOCKED);

  // A full VC refuses even when it is being drained this cycle
  assign ready_o = !full_v[vc_id_i] && !(opens && tgt_locked);
  assign wr_acc  = valid_i && ready_o;

  // BODY/TAIL with no open packet is swallowed: handshake completes but nothing is stored
  assign orphan  = !opens && !tgt_locked;
  assign store   = wr_acc && !orphan;
  assign wr_err  = wr_acc && orphan;

  assign rd_ok   = ready_i && !empty_v[rd_vc_i];
  assign rd_err  = ready_i &&  empty_v[rd_vc_i];

  assign valid_o = ~empty_v;
  assign error_o = err_q;

  genvar g;
  generate
    for (g = 0; g < NUM_VC; g++) begin : g_vc
      vc_fifo #(
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH)
      ) u_fifo (
        .clk    (clk),
        .arst   (arst),
        .wr_en  (store && (vc_id_i == VC_W'(g))),
        .wr_dat (fdata_i),
        .rd_en  (rd_ok && (rd_vc_i == VC_W'(g))),
        .rd_dat (rd_dat_a[g]),
        .full   (full_v[g]),
        .empty  (empty_v[g]),
        .ocup   (ocup_a[g])
      );

      assign ocup_o[g*OCC_W +: OCC_W] = ocup_a[g];
      assign locked_o[g]              = (lock_q[g] == LOCKED);
    end
  endgenerate

  // Lock state register for every VC
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      for (int v = 0; v < NUM_VC; v++) lock_q[v] <= UNLOCKED;
    end else begin
      for (int v = 0; v < NUM_VC; v++) lock_q[v] <= lock_d[v];
    end
  end

  // Lock next state: accepted HEAD opens, accepted TAIL closes, HEADTAIL/BODY leave it alone
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      lock_d[v] = lock_q[v];
      if (wr_acc && (vc_id_i == VC_W'(v))) begin
        if (in_type == HEAD) begin
          lock_d[v] = LOCKED;
        end else if (in_type == TAIL) begin
          lock_d[v] = UNLOCKED;
        end
      end
    end
  end

  // Oldest flit of the selected VC, forced to zero when that VC holds nothing
  always_comb begin
    fdata_o = '0;
    if (!empty_v[rd_vc_i]) begin
      fdata_o = rd_dat_a[rd_vc_i];
    end
  end

  // Registered single-cycle error pulse from either violation source
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= wr_err || rd_err;
    end
  end

endmodule

// File: doc/vc_input_buffer.md
VC_INPUT_BUFFER -- requirements
Module: vc_input_buffer

Interface
REQ-001 Parameter FLIT_W, default 34, flit width in bits; bits [FLIT_W-1:FLIT_W-2] hold the flit type.
REQ-002 Parameter NUM_VC, default 4, number of virtual channels; must be ≥2 and a power of 2; VC_W = log2(NUM_VC).
REQ-003 Parameter DEPTH, default 4, flits per VC; must be ≥2 and a power of 2; OCC_W = log2(DEPTH)+1.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 arst  in  1  asynchronous, active-low reset: 0 resets, 1 runs.
REQ-006 vc_id_i  in  VC_W  target VC of the incoming flit.
REQ-007 fdata_i  in  FLIT_W  incoming flit.
REQ-008 valid_i  in  1  incoming flit valid.
REQ-009 ready_o  out  1  combinational; the flit on fdata_i/vc_id_i is accepted this cycle.
REQ-010 rd_vc_i  in  VC_W  VC selected for read by the downstream arbiter.
REQ-011 ready_i  in  1  downstream accepts fdata_o.
REQ-012 fdata_o  out  FLIT_W  oldest flit of VC rd_vc_i; all-zero when that VC is empty.
REQ-013 valid_o  out  NUM_VC  bit v = VC v is non-empty.
REQ-014 ocup_o  out  NUM_VC*OCC_W  registered occupancy per VC (0..DEPTH), VC v at slice [v*OCC_W +: OCC_W].
REQ-015 locked_o  out  NUM_VC  bit v = VC v holds an open packet (head accepted, tail not yet accepted).
REQ-016 error_o  out  1  registered one-cycle pulse on a protocol violation.

Function
REQ-017 Flit type encoding: 00 HEAD, 01 BODY, 10 HEADTAIL, 11 TAIL.
REQ-018 ready_o = !full[vc_id_i] AND NOT((type ∈ {HEAD, HEADTAIL}) AND locked[vc_id_i]).
REQ-019 A write occurs when valid_i AND ready_o; the flit is stored at the write pointer of VC vc_id_i.
REQ-020 Per-VC lock state machine, UNLOCKED→LOCKED on an accepted HEAD; LOCKED→UNLOCKED on an accepted TAIL; HEADTAIL and BODY do not change the state.
REQ-021 BODY or TAIL offered to an UNLOCKED VC: ready_o=1, flit dropped (not stored), error_o=1 on the next cycle, lock state unchanged.
REQ-022 Write latency: a flit written in cycle N is visible on valid_o/fdata_o in cycle N+1; there is no same-cycle bypass.
REQ-023 A read occurs when ready_i AND valid_o[rd_vc_i]; the read pointer of that VC advances by one.
REQ-024 ready_i with an empty rd_vc_i: no pointer change and error_o=1 on the next cycle.
REQ-025 Pointers are log2(DEPTH)+1 bits with a wrap bit; empty = pointers equal; full = low bits equal and wrap bits differ; wrap from DEPTH-1 to 0 is seamless.
REQ-026 A simultaneous read and write on the same VC are both performed and the occupancy is unchanged; a full VC refuses the write even when it is being read in the same cycle.
REQ-027 Writes and reads on different VCs in the same cycle are independent.
REQ-028 ocup_o[v] equals the occupancy after the current edge's updates.
REQ-029 error_o is the OR of both violation sources, delayed by one cycle.

Reset
REQ-030 While arst=0: all pointers, ocup_o, locked_o, valid_o and error_o are 0, and fdata_o is 0; the storage array is not reset.
REQ-031 Reset asserted mid-packet discards all stored flits and clears all locks immediately, without waiting for a clock edge.
REQ-032 The first write is accepted on the first rising edge after arst deasserts.

Structure
REQ-033 Package vc_buffer_pkg holds the flit type localparams (HEAD, BODY, HEADTAIL, TAIL) and the default FLIT_W, NUM_VC and DEPTH.
REQ-034 Sub-module vc_fifo (a single-VC FIFO with pointers, full/empty and occupancy) is instantiated NUM_VC times using generate; lock logic, input steering and output muxing live in the top module.

Verification
REQ-035 Scenario: after reset, send HEAD, BODY, TAIL on VC2 with ready_i=0 -> ocup_o[2] counts 1,2,3; locked_o[2] reads 1,1,0; rd_vc_i=2 with ready_i=1 returns the flits in order.
REQ-036 Scenario: with DEPTH=4, write 4 flits to VC0 -> ready_o=0 for a 5th flit to VC0 while ready_o=1 for VC1; reading one flit from VC0 re-enables ready_o in the next cycle.
REQ-037 Scenario: HEAD to VC1, then a second HEAD to VC1 -> ready_o=0 for the second HEAD; a HEADTAIL to VC3 in the same state is accepted and locked_o[3] stays 0.
REQ-038 Scenario: TAIL to an unlocked VC0 -> ready_o=1, ocup_o[0] stays 0, error_o=1 for exactly one cycle.
REQ-039 Scenario: VC0 full, read VC0 and offer a write to VC0 in the same cycle -> write refused, occupancy becomes 3; 10 write/read pairs over the wrap point return data in order.
REQ-040 Scenario: arst=0 asserted between clock edges with VC0 locked and holding 2 flits -> locked_o, valid_o and ocup_o drop to 0 before the next edge.
